// File: rtl/playbus_controller_l2.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | playbus_controller_l2 : multi-cycle PlayBus strobe sequencer, wait states   |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module playbus_controller_l2 #(
   parameter int ROM_WAIT = 0,
   parameter int RAM_WAIT = 1,
   parameter int N_LED    = 2,
   localparam int SW      = (N_LED > 1) ? $clog2(N_LED) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       func,
   input  logic [SW-1:0]    sel,
   output logic             ROMO,
   output logic             RAMO,
   output logic             RAMW,
   output logic             SWBEN,
   output logic [N_LED-1:0] LEDLTCH,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [4:0]  ROM_LEN  = 5'(ROM_WAIT + 1);
   localparam logic [4:0]  RAM_LEN  = 5'(RAM_WAIT + 1);
   localparam logic [SW:0] N_LED_W  = (SW+1)'(N_LED);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_XFER  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t        state, state_n;
   logic [4:0]    cnt, cnt_n;
   logic [2:0]    func_q;
   logic [SW-1:0] sel_q;
   logic          active, led_func, sel_ok;

   function automatic logic [4:0] setup_len(input logic [2:0] f);
      case (f)
         3'd3, 3'd6: setup_len = 5'd1;
         3'd4, 3'd7: setup_len = ROM_LEN;
         3'd5:       setup_len = RAM_LEN;
         default:    setup_len = 5'd0;
      endcase
   endfunction

   function automatic logic [4:0] xfer_len(input logic [2:0] f);
      case (f)
         3'd0:             xfer_len = 5'd0;
         3'd1:             xfer_len = ROM_LEN;
         3'd2, 3'd3, 3'd4: xfer_len = RAM_LEN;
         default:          xfer_len = 5'd1;
      endcase
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= 5'd0;
         func_q <= 3'd0;
         sel_q  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (state == ST_IDLE && start) begin
            func_q <= func;
            sel_q  <= sel;
         end
      end
   end

   // Counter holds remaining cycles minus one; reloaded on every phase entry.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (setup_len(func) != 5'd0) begin
                  state_n = ST_SETUP;
                  cnt_n   = setup_len(func) - 5'd1;
               end else if (xfer_len(func) != 5'd0) begin
                  state_n = ST_XFER;
                  cnt_n   = xfer_len(func) - 5'd1;
               end else begin
                  state_n = ST_DONE;
                  cnt_n   = 5'd0;
               end
            end
         end
         ST_SETUP: begin
            if (cnt == 5'd0) begin
               state_n = ST_XFER;
               cnt_n   = xfer_len(func_q) - 5'd1;
            end else begin
               cnt_n = cnt - 5'd1;
            end
         end
         ST_XFER: begin
            if (cnt == 5'd0) state_n = ST_DONE;
            else             cnt_n   = cnt - 5'd1;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      active   = (state == ST_SETUP) || (state == ST_XFER);
      led_func = func_q inside {3'd5, 3'd6, 3'd7};
      sel_ok   = {1'b0, sel_q} < N_LED_W;
      busy     = active;
      done     = (state == ST_DONE);
      err      = done && led_func && !sel_ok;
      ROMO     = active && (func_q inside {3'd1, 3'd4, 3'd7});
      RAMO     = active && (func_q inside {3'd2, 3'd5});
      SWBEN    = active && (func_q inside {3'd3, 3'd6});
      RAMW     = (state == ST_XFER) && (func_q inside {3'd3, 3'd4});
      for (int i = 0; i < N_LED; i++) begin
         LEDLTCH[i] = (state == ST_XFER) && led_func && sel_ok && (sel_q == SW'(i));
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_playbus_controller_l2.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_playbus_controller_l2 : directed bench, three parameter sets             |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_playbus_controller_l2;

   // packed observation: [11]err [10]done [9]busy [8:4]LEDLTCH [3]SWBEN [2]RAMW [1]RAMO [0]ROMO
   localparam logic [11:0] B_ROMO = 12'h001;
   localparam logic [11:0] B_RAMO = 12'h002;
   localparam logic [11:0] B_RAMW = 12'h004;
   localparam logic [11:0] B_SWB  = 12'h008;
   localparam logic [11:0] B_BUSY = 12'h200;
   localparam logic [11:0] B_DONE = 12'h400;
   localparam logic [11:0] B_ERR  = 12'h800;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_v [3];
   logic [2:0]  func;
   logic [2:0]  sel;
   logic [11:0] obs_v [3];
   int          n_total = 0;
   int          n_pass  = 0;

   logic        romo1, ramo1, ramw1, swb1, busy1, done1, err1;
   logic [4:0]  led1;
   logic        romo2, ramo2, ramw2, swb2, busy2, done2, err2;
   logic [3:0]  led2;
   logic        romo3, ramo3, ramw3, swb3, busy3, done3, err3;
   logic [0:0]  led3;

   always #5 clk = ~clk;

   playbus_controller_l2 #(.ROM_WAIT(0), .RAM_WAIT(1), .N_LED(5)) u_dut1 (
      .clk(clk), .reset(reset), .start(start_v[0]), .func(func), .sel(sel),
      .ROMO(romo1), .RAMO(ramo1), .RAMW(ramw1), .SWBEN(swb1), .LEDLTCH(led1),
      .busy(busy1), .done(done1), .err(err1));

   playbus_controller_l2 #(.ROM_WAIT(3), .RAM_WAIT(0), .N_LED(4)) u_dut2 (
      .clk(clk), .reset(reset), .start(start_v[1]), .func(func), .sel(sel[1:0]),
      .ROMO(romo2), .RAMO(ramo2), .RAMW(ramw2), .SWBEN(swb2), .LEDLTCH(led2),
      .busy(busy2), .done(done2), .err(err2));

   playbus_controller_l2 #(.ROM_WAIT(15), .RAM_WAIT(15), .N_LED(1)) u_dut3 (
      .clk(clk), .reset(reset), .start(start_v[2]), .func(func), .sel(sel[0:0]),
      .ROMO(romo3), .RAMO(ramo3), .RAMW(ramw3), .SWBEN(swb3), .LEDLTCH(led3),
      .busy(busy3), .done(done3), .err(err3));

   assign obs_v[0] = {err1, done1, busy1, led1, swb1, ramw1, ramo1, romo1};
   assign obs_v[1] = {err2, done2, busy2, 1'b0, led2, swb2, ramw2, ramo2, romo2};
   assign obs_v[2] = {err3, done3, busy3, 4'b0, led3, swb3, ramw3, ramo3, romo3};

   function automatic logic [11:0] led_bit(input int n);
      led_bit = 12'h010 << n;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called at cycle 1 (just after the accepting edge); ends in the idle cycle after DONE.
   task automatic check_seq(input int idx, input string tag, input int s, input int t,
                            input logic [11:0] src, input logic [11:0] xm, input logic e);
      logic [11:0] exp;
      for (int c = 1; c <= s + t + 2; c++) begin
         if (c <= s)              exp = B_BUSY | src;
         else if (c <= s + t)     exp = B_BUSY | src | xm;
         else if (c == s + t + 1) exp = B_DONE | (e ? B_ERR : 12'h000);
         else                     exp = 12'h000;
         check($sformatf("%s c%0d", tag, c), 32'(obs_v[idx]), 32'(exp));
         if (c < s + t + 2) step();
      end
   endtask

   task automatic op(input int idx, input string tag, input logic [2:0] f, input logic [2:0] s_in,
                     input int s, input int t, input logic [11:0] src, input logic [11:0] xm,
                     input logic e);
      func = f;
      sel  = s_in;
      start_v[idx] = 1'b1;
      step();
      start_v[idx] = 1'b0;
      func = 3'd0;
      sel  = 3'd0;
      check_seq(idx, tag, s, t, src, xm, e);
   endtask

   initial begin
      reset = 1'b1;
      func  = 3'd0;
      sel   = 3'd0;
      for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
      #3;
      for (int i = 0; i < 3; i++) check($sformatf("reset dut%0d", i), 32'(obs_v[i]), 32'h0);
      step();
      step();
      reset = 1'b0;
      step();

      // ROM_WAIT=0, RAM_WAIT=1, N_LED=5
      op(0, "d1 f4",       3'd4, 3'd0, 1, 2, B_ROMO, B_RAMW,    1'b0);
      op(0, "d1 f5 sel2",  3'd5, 3'd2, 2, 1, B_RAMO, led_bit(2), 1'b0);
      op(0, "d1 f5 sel4",  3'd5, 3'd4, 2, 1, B_RAMO, led_bit(4), 1'b0);
      op(0, "d1 f7 sel5",  3'd7, 3'd5, 1, 1, B_ROMO, 12'h000,   1'b1);
      op(0, "d1 f6 sel7",  3'd6, 3'd7, 1, 1, B_SWB,  12'h000,   1'b1);
      op(0, "d1 f0",       3'd0, 3'd0, 0, 0, 12'h0,  12'h000,   1'b0);
      op(0, "d1 f3",       3'd3, 3'd1, 1, 2, B_SWB,  B_RAMW,    1'b0);
      op(0, "d1 f1",       3'd1, 3'd0, 0, 1, B_ROMO, 12'h000,   1'b0);

      // start retoggled and func changed mid-op must be ignored
      func = 3'd2;
      start_v[0] = 1'b1;
      step();
      start_v[0] = 1'b1;
      func = 3'd1;
      check("tog c1", 32'(obs_v[0]), 32'(B_BUSY | B_RAMO));
      step();
      start_v[0] = 1'b0;
      check("tog c2", 32'(obs_v[0]), 32'(B_BUSY | B_RAMO));
      step();
      start_v[0] = 1'b1;
      check("tog c3", 32'(obs_v[0]), 32'(B_DONE));
      step();
      start_v[0] = 1'b0;
      check("tog c4", 32'(obs_v[0]), 32'h0);
      step();
      check("tog c5", 32'(obs_v[0]), 32'h0);

      // asynchronous reset during XFER of func=4
      func = 3'd4;
      start_v[0] = 1'b1;
      step();
      start_v[0] = 1'b0;
      step();
      check("pre-rst xfer", 32'(obs_v[0]), 32'(B_BUSY | B_ROMO | B_RAMW));
      #2 reset = 1'b1;
      #1;
      check("rst async", 32'(obs_v[0]), 32'h0);
      step();
      check("rst held", 32'(obs_v[0]), 32'h0);
      reset = 1'b0;
      step();
      check("rst released", 32'(obs_v[0]), 32'h0);
      op(0, "d1 post-rst f1", 3'd1, 3'd0, 0, 1, B_ROMO, 12'h000, 1'b0);

      // ROM_WAIT=3, RAM_WAIT=0, N_LED=4; start held high across all functions
      sel  = 3'd3;
      func = 3'd0;
      start_v[1] = 1'b1;
      for (int f = 0; f < 8; f++) begin
         int s, t;
         logic [11:0] src, xm;
         case (f)
            0:       begin s = 0; t = 0; src = 12'h0;  xm = 12'h0;      end
            1:       begin s = 0; t = 4; src = B_ROMO; xm = 12'h0;      end
            2:       begin s = 0; t = 1; src = B_RAMO; xm = 12'h0;      end
            3:       begin s = 1; t = 1; src = B_SWB;  xm = B_RAMW;     end
            4:       begin s = 4; t = 1; src = B_ROMO; xm = B_RAMW;     end
            5:       begin s = 1; t = 1; src = B_RAMO; xm = led_bit(3); end
            6:       begin s = 1; t = 1; src = B_SWB;  xm = led_bit(3); end
            default: begin s = 4; t = 1; src = B_ROMO; xm = led_bit(3); end
         endcase
         step();
         func = 3'((f + 1) % 8);
         check_seq(1, $sformatf("d2 run f%0d", f), s, t, src, xm, 1'b0);
      end
      start_v[1] = 1'b0;
      step();
      check("d2 stop", 32'(obs_v[1]), 32'h0);

      // ROM_WAIT=15, RAM_WAIT=15, N_LED=1
      op(2, "d3 f4",      3'd4, 3'd0, 16, 16, B_ROMO, B_RAMW,    1'b0);
      op(2, "d3 f1",      3'd1, 3'd0, 0,  16, B_ROMO, 12'h000,   1'b0);
      op(2, "d3 f5 sel0", 3'd5, 3'd0, 16, 1,  B_RAMO, led_bit(0), 1'b0);
      op(2, "d3 f6 sel1", 3'd6, 3'd1, 1,  1,  B_SWB,  12'h000,   1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
